// File: rtl/spike_encoder_array.sv
// spike_encoder_array: latches a volley of per-channel spike times and replays it over one gamma cycle.
// Optional step mode (held spikes) is enabled by defining SPIKE_STEP_MODE_EN.
module spike_encoder_array #(
    parameter int N_CH = 16,
    parameter int TIME_PERIOD = 8,
    parameter int TW = $clog2(TIME_PERIOD)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_CH*TW-1:0]   in_spike_time,
    input  logic [N_CH-1:0]      in_should_spike,
`ifdef SPIKE_STEP_MODE_EN
    input  logic                 step_mode,
`endif
    output logic [TW-1:0]        time_val,
    output logic [N_CH-1:0]      spike_out,
    output logic                 busy,
    output logic                 gamma_done
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nx;
    logic [TW-1:0] t, t_nx;
    logic [N_CH*TW-1:0] st, st_nx;
    logic [N_CH-1:0] en, en_nx;
    logic last, accept;
    assign last = state == RUN && t == TW'(TIME_PERIOD - 1);
    assign in_ready = state == IDLE || last;
    assign accept = in_valid && in_ready;
    assign busy = state == RUN;
    assign gamma_done = last;
    assign time_val = t;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            t <= '0;
            st <= '0;
            en <= '0;
        end else begin
            state <= state_nx;
            t <= t_nx;
            st <= st_nx;
            en <= en_nx;
        end
    end
    // flush wins over an accept; the last tick either chains a new volley or drops to IDLE
    always_comb begin
        state_nx = state;
        t_nx = t;
        st_nx = st;
        en_nx = en;
        if (flush) begin
            state_nx = IDLE;
            t_nx = '0;
            st_nx = '0;
            en_nx = '0;
        end else if (accept) begin
            state_nx = RUN;
            t_nx = '0;
            st_nx = in_spike_time;
            en_nx = in_should_spike;
        end else if (last) begin
            state_nx = IDLE;
            t_nx = '0;
        end else if (state == RUN) begin
            t_nx = t + TW'(1);
        end
    end
`ifdef SPIKE_STEP_MODE_EN
    logic sm, sm_nx;
    always_ff @(posedge clk) sm <= !rst_n ? 1'b0 : sm_nx;
    always_comb sm_nx = flush ? 1'b0 : accept ? step_mode : sm;
`else
    logic sm;
    assign sm = 1'b0;
`endif
    // t never reaches TIME_PERIOD, so out-of-range times never fire in either mode
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign spike_out[i] = busy && en[i] &&
            (sm ? st[i*TW +: TW] <= t : st[i*TW +: TW] == t);
    end
endmodule

// File: tb/tb_spike_encoder_array.sv
// tb_spike_encoder_array: two instances (TIME_PERIOD 8 and 6) share stimulus and are
// checked every cycle against a tick-counting reference model.
module tb_spike_encoder_array;
    logic clk = 0;
    logic rst_n, flush, in_valid, sm_in;
    logic [11:0] times;
    logic [3:0] ens;
    logic rdy [2];
    logic [2:0] tv [2];
    logic [3:0] spk [2];
    logic bsy [2];
    logic gd [2];
    int checks = 0;
    int failures = 0;
    int tick [2];
    int mt [2][4];
    bit me [2][4];
    bit msm [2];
    always #5 clk = ~clk;

    spike_encoder_array #(.N_CH(4), .TIME_PERIOD(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_spike_time(times), .in_should_spike(ens),
`ifdef SPIKE_STEP_MODE_EN
        .step_mode(sm_in),
`endif
        .time_val(tv[0]), .spike_out(spk[0]), .busy(bsy[0]), .gamma_done(gd[0]));

    spike_encoder_array #(.N_CH(4), .TIME_PERIOD(6)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_spike_time(times), .in_should_spike(ens),
`ifdef SPIKE_STEP_MODE_EN
        .step_mode(sm_in),
`endif
        .time_val(tv[1]), .spike_out(spk[1]), .busy(bsy[1]), .gamma_done(gd[1]));

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut%0d got=%0h exp=%0h", tag, k, obs, exp);
        end
    endtask

    function automatic int period(input int k);
        return k == 0 ? 8 : 6;
    endfunction

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            int p = period(k);
            bit idle = tick[k] < 0;
            logic [3:0] e = '0;
            for (int c = 0; c < 4; c++)
                e[c] = !idle && me[k][c] && (msm[k] ? mt[k][c] <= tick[k] : mt[k][c] == tick[k]);
            chk("in_ready", k, 32'(rdy[k]), 32'(idle || tick[k] == p - 1));
            chk("busy", k, 32'(bsy[k]), 32'(!idle));
            chk("time_val", k, 32'(tv[k]), idle ? 0 : tick[k]);
            chk("gamma_done", k, 32'(gd[k]), 32'(tick[k] == p - 1));
            chk("spike_out", k, 32'(spk[k]), 32'(e));
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int p = period(k);
            bit ready = tick[k] < 0 || tick[k] == p - 1;
            if (!rst_n || flush) begin
                tick[k] = -1;
                msm[k] = 0;
                for (int c = 0; c < 4; c++) begin mt[k][c] = 0; me[k][c] = 0; end
            end else if (in_valid && ready) begin
                tick[k] = 0;
`ifdef SPIKE_STEP_MODE_EN
                msm[k] = sm_in;
`else
                msm[k] = 0;
`endif
                for (int c = 0; c < 4; c++) begin mt[k][c] = int'(times[c*3 +: 3]); me[k][c] = ens[c]; end
            end else if (tick[k] == p - 1) tick[k] = -1;
            else if (tick[k] >= 0) tick[k]++;
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            check_all();
            model_step();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_vol(input int a, input int b, input int c, input int d, input logic [3:0] e);
        times = {3'(d), 3'(c), 3'(b), 3'(a)};
        ens = e;
    endtask

    initial begin
        rst_n = 0; flush = 0; in_valid = 0; sm_in = 0; times = '0; ens = '0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            tick[k] = -1; msm[k] = 0;
            for (int c = 0; c < 4; c++) begin mt[k][c] = 0; me[k][c] = 0; end
        end
        rst_n = 1;
        cyc(2);
        // basic volley: ch0@0, ch1@3, ch3@5, ch2 disabled
        set_vol(0, 3, 7, 5, 4'b1011); in_valid = 1;
        cyc(1);
        in_valid = 0; set_vol(1, 1, 1, 1, 4'b1111);
        cyc(10);
        // times 6 and 7 are null spikes on the period-6 instance
        set_vol(6, 2, 7, 1, 4'b1111); in_valid = 1;
        cyc(1);
        in_valid = 0;
        cyc(9);
        // back-to-back volleys with in_valid held high
        in_valid = 1;
        for (int i = 0; i < 18; i++) begin
            set_vol($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 4'($urandom));
            cyc(1);
        end
        in_valid = 0;
        cyc(9);
        // flush at t3 alongside a pending volley
        set_vol(5, 4, 6, 2, 4'b1111); in_valid = 1;
        cyc(1);
        in_valid = 0;
        cyc(3);
        flush = 1; in_valid = 1; set_vol(0, 0, 0, 0, 4'b1111);
        cyc(1);
        flush = 0; in_valid = 0;
        cyc(3);
        // reset mid-run at t4 then restart
        set_vol(5, 6, 4, 7, 4'b1111); in_valid = 1;
        cyc(1);
        in_valid = 0;
        cyc(4);
        rst_n = 0; in_valid = 1; flush = 1;
        cyc(1);
        rst_n = 1; flush = 0; set_vol(2, 0, 1, 3, 4'b1111);
        cyc(1);
        in_valid = 0;
        cyc(9);
`ifdef SPIKE_STEP_MODE_EN
        sm_in = 1; set_vol(2, 6, 7, 0, 4'b0001); in_valid = 1;
        cyc(1);
        in_valid = 0; sm_in = 0;
        cyc(10);
`endif
        for (int i = 0; i < 400; i++) begin
            rst_n = $urandom_range(0, 99) >= 3;
            flush = $urandom_range(0, 99) < 5;
            in_valid = $urandom_range(0, 1) == 1;
`ifdef SPIKE_STEP_MODE_EN
            sm_in = $urandom_range(0, 1) == 1;
`endif
            set_vol($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 4'($urandom));
            cyc(1);
        end
        rst_n = 1; flush = 0; in_valid = 0;
        cyc(10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
